// File: rtl/treemux_rr_arbiter.sv
// Round-robin, packet-locking arbiter for one treemux output channel.
// Grants one requester until its last flit is accepted; output is registered.
module treemux_rr_arbiter #(
    parameter int WIDTH = 72,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_data [N-1:0],
    input  logic [N-1:0]     in_valid,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [IDW-1:0]   grant_id,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] own;

    logic           can_load;
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] sel;
    logic [IDW:0]   scan;
    logic           xfer;
    logic [IDW-1:0] sel_next;

    assign can_load = !out_valid || out_ready;

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int o = 0; o < N; o++) begin
            scan = {1'b0, rr_ptr} + (IDW + 1)'(o);
            if (scan >= (IDW + 1)'(N)) begin
                scan = scan - (IDW + 1)'(N);
            end
            if (!found && in_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                win   = scan[IDW-1:0];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        sel      = (state == LOCKED) ? own : win;
        if (!RST && can_load && (state == LOCKED || found)) begin
            in_ready[sel] = 1'b1;
        end
    end

    assign xfer     = in_valid[sel] && in_ready[sel];
    assign sel_next = (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);
    assign busy     = (state == LOCKED) || out_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            own       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            grant_id  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (xfer) begin
                out_data  <= in_data[sel];
                out_last  <= in_last[sel];
                out_valid <= 1'b1;
                grant_id  <= sel;
                if (in_last[sel]) begin
                    state  <= IDLE;
                    rr_ptr <= sel_next;
                end else begin
                    state <= LOCKED;
                    own   <= sel;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_treemux_rr_arbiter.sv
// Directed bench for treemux_rr_arbiter (N=4): reset, rotation, locking,
// backpressure, owner gaps and mid-packet reset, with hand-computed expectations.
module tb_treemux_rr_arbiter;

    localparam int WIDTH = 72;
    localparam int N     = 4;
    localparam int IDW   = 2;

    logic             CLK;
    logic             RST;
    logic [WIDTH-1:0] in_data [N-1:0];
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_last;
    logic [N-1:0]     in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [IDW-1:0]   grant_id;
    logic             busy;

    int vectors;
    int miscompares;

    treemux_rr_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i] = WIDTH'(i);
        for (int c = 0; c < 3; c++) begin
            cyc();
            vectors++; if (in_ready !== 4'b0000) begin $display("FAIL reset_in_ready: got %b want 0000", in_ready); miscompares++; end
            vectors++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); miscompares++; end
            vectors++; if (grant_id !== 2'd0) begin $display("FAIL reset_grant_id: got %0d want 0", grant_id); miscompares++; end
            vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); miscompares++; end
            vectors++; if (out_data !== '0 || out_last !== 1'b0) begin $display("FAIL reset_out_data: got %0h/%b want 0/0", out_data, out_last); miscompares++; end
        end
        RST = 1'b0;
        settle();
        vectors++; if (in_ready !== 4'b0001) begin $display("FAIL release_in_ready: got %b want 0001", in_ready); miscompares++; end
        in_valid = 4'b0000;
        cyc();
        vectors++; if (out_valid !== 1'b0) begin $display("FAIL release_no_xfer: got out_valid %b want 0", out_valid); miscompares++; end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ready;
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i] = WIDTH'(i);
        for (int k = 0; k < 8; k++) begin
            exp_ready = 4'b0001 << (k % N);
            settle();
            vectors++; if (in_ready !== exp_ready) begin $display("FAIL rr_in_ready[%0d]: got %b want %b", k, in_ready, exp_ready); miscompares++; end
            cyc();
            vectors++; if (out_valid !== 1'b1 || out_data !== WIDTH'(k % N)) begin $display("FAIL rr_out[%0d]: got v=%b d=%0h want v=1 d=%0h", k, out_valid, out_data, k % N); miscompares++; end
            vectors++; if (grant_id !== IDW'(k % N)) begin $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant_id, k % N); miscompares++; end
        end
        in_valid = 4'b0000;
        cyc();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin $display("FAIL rr_drain: got v=%b busy=%b want 0/0", out_valid, busy); miscompares++; end
    endtask

    task automatic test_packet_lock();
        // Single flit from req 1 moves the pointer to 2.
        in_valid   = 4'b0010;
        in_last    = 4'b1111;
        in_data[1] = WIDTH'(1);
        cyc();
        vectors++; if (out_data !== WIDTH'(1) || grant_id !== 2'd1) begin $display("FAIL lock_setup: got d=%0h g=%0d want 1/1", out_data, grant_id); miscompares++; end
        in_valid   = 4'b0111;
        in_last    = 4'b0011;
        in_data[0] = WIDTH'(0);
        in_data[2] = WIDTH'('h20);
        for (int f = 0; f < 3; f++) begin
            in_data[2] = WIDTH'('h20 + f);
            in_last[2] = (f == 2);
            settle();
            vectors++; if (in_ready !== 4'b0100) begin $display("FAIL lock_in_ready[%0d]: got %b want 0100", f, in_ready); miscompares++; end
            cyc();
            vectors++; if (out_data !== WIDTH'('h20 + f) || grant_id !== 2'd2) begin $display("FAIL lock_out[%0d]: got d=%0h g=%0d want %0h/2", f, out_data, grant_id, 'h20 + f); miscompares++; end
            vectors++; if (out_last !== (f == 2) || busy !== 1'b1) begin $display("FAIL lock_last[%0d]: got last=%b busy=%b want %b/1", f, out_last, busy, f == 2); miscompares++; end
        end
        // Pointer is now 3; req 3 idle, so req 0 wins next.
        in_valid = 4'b0011;
        settle();
        vectors++; if (in_ready !== 4'b0001) begin $display("FAIL lock_next_ready: got %b want 0001", in_ready); miscompares++; end
        cyc();
        vectors++; if (out_data !== WIDTH'(0) || grant_id !== 2'd0 || out_last !== 1'b1) begin $display("FAIL lock_next_out: got d=%0h g=%0d l=%b want 0/0/1", out_data, grant_id, out_last); miscompares++; end
        in_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_backpressure();
        // Pointer is 1; req 1 sends 4 flits while req 0 stays valid.
        in_valid   = 4'b0011;
        in_last    = 4'b0001;
        for (int f = 0; f < 2; f++) begin
            in_data[1] = WIDTH'('h10 + f);
            settle();
            vectors++; if (in_ready !== 4'b0010) begin $display("FAIL bp_in_ready[%0d]: got %b want 0010", f, in_ready); miscompares++; end
            cyc();
            vectors++; if (out_data !== WIDTH'('h10 + f) || out_valid !== 1'b1) begin $display("FAIL bp_pre[%0d]: got d=%0h v=%b want %0h/1", f, out_data, out_valid, 'h10 + f); miscompares++; end
        end
        in_data[1] = WIDTH'('h12);
        out_ready  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            vectors++; if (in_ready !== 4'b0000) begin $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, in_ready); miscompares++; end
            cyc();
            vectors++; if (out_data !== WIDTH'('h11) || out_valid !== 1'b1) begin $display("FAIL bp_stall_out[%0d]: got d=%0h v=%b want 11/1", c, out_data, out_valid); miscompares++; end
        end
        out_ready = 1'b1;
        for (int f = 2; f < 4; f++) begin
            in_data[1] = WIDTH'('h10 + f);
            in_last[1] = (f == 3);
            settle();
            vectors++; if (in_ready !== 4'b0010) begin $display("FAIL bp_resume_ready[%0d]: got %b want 0010", f, in_ready); miscompares++; end
            cyc();
            vectors++; if (out_data !== WIDTH'('h10 + f) || out_last !== (f == 3)) begin $display("FAIL bp_resume_out[%0d]: got d=%0h l=%b want %0h/%b", f, out_data, out_last, 'h10 + f, f == 3); miscompares++; end
        end
        in_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_owner_gap();
        // Pointer is 2; req 1 alone wins, then req 3 shows up during the gap.
        in_valid   = 4'b0010;
        in_last    = 4'b1000;
        in_data[1] = WIDTH'('h30);
        in_data[3] = WIDTH'('h3f);
        settle();
        vectors++; if (in_ready !== 4'b0010) begin $display("FAIL gap_first_ready: got %b want 0010", in_ready); miscompares++; end
        cyc();
        vectors++; if (out_data !== WIDTH'('h30) || grant_id !== 2'd1) begin $display("FAIL gap_first_out: got d=%0h g=%0d want 30/1", out_data, grant_id); miscompares++; end
        in_valid = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            settle();
            vectors++; if (in_ready !== 4'b0010) begin $display("FAIL gap_ready[%0d]: got %b want 0010", c, in_ready); miscompares++; end
            cyc();
            vectors++; if (busy !== 1'b1 || grant_id !== 2'd1) begin $display("FAIL gap_busy[%0d]: got busy=%b g=%0d want 1/1", c, busy, grant_id); miscompares++; end
        end
        vectors++; if (out_valid !== 1'b0) begin $display("FAIL gap_out_valid: got %b want 0", out_valid); miscompares++; end
        in_valid   = 4'b1010;
        in_last    = 4'b1010;
        in_data[1] = WIDTH'('h31);
        cyc();
        vectors++; if (out_data !== WIDTH'('h31) || grant_id !== 2'd1 || out_last !== 1'b1) begin $display("FAIL gap_resume: got d=%0h g=%0d l=%b want 31/1/1", out_data, grant_id, out_last); miscompares++; end
        in_valid = 4'b1000;
        settle();
        vectors++; if (in_ready !== 4'b1000) begin $display("FAIL gap_next_ready: got %b want 1000", in_ready); miscompares++; end
        cyc();
        vectors++; if (out_data !== WIDTH'('h3f) || grant_id !== 2'd3) begin $display("FAIL gap_next_out: got d=%0h g=%0d want 3f/3", out_data, grant_id); miscompares++; end
        in_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_reset_mid_packet();
        // Pointer is 0; a single flit from req 2 moves it to 3.
        in_valid   = 4'b0100;
        in_last    = 4'b1111;
        in_data[2] = WIDTH'('h2a);
        cyc();
        in_valid = 4'b0001;
        in_last  = 4'b0000;
        for (int f = 0; f < 2; f++) begin
            in_data[0] = WIDTH'('h40 + f);
            cyc();
            vectors++; if (out_data !== WIDTH'('h40 + f) || grant_id !== 2'd0) begin $display("FAIL mid_flit[%0d]: got d=%0h g=%0d want %0h/0", f, out_data, grant_id, 'h40 + f); miscompares++; end
        end
        in_data[0] = WIDTH'('h42);
        in_valid   = 4'b0101;
        RST        = 1'b1;
        settle();
        vectors++; if (in_ready !== 4'b0000) begin $display("FAIL mid_rst_ready: got %b want 0000", in_ready); miscompares++; end
        cyc();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin $display("FAIL mid_rst_state: got v=%b busy=%b want 0/0", out_valid, busy); miscompares++; end
        RST        = 1'b0;
        in_valid   = 4'b1001;
        in_last    = 4'b1111;
        in_data[0] = WIDTH'('h50);
        in_data[3] = WIDTH'('h53);
        settle();
        vectors++; if (in_ready !== 4'b0001) begin $display("FAIL mid_restart_ready: got %b want 0001", in_ready); miscompares++; end
        cyc();
        vectors++; if (out_data !== WIDTH'('h50) || grant_id !== 2'd0) begin $display("FAIL mid_restart_out: got d=%0h g=%0d want 50/0", out_data, grant_id); miscompares++; end
        in_valid = 4'b0000;
        cyc();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = '0;
        in_last     = '0;
        out_ready   = 1'b1;
        RST         = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_owner_gap();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
